// File: rtl/systolic_requant_if.sv
// systolic_requant_if: row input, config port and packed int8 output bus of systolic_requant.
interface systolic_requant_if #(
    parameter int AR_SIZE = 4
);
    logic                  in_wr_en;
    logic [15:0]           in_index;
    logic [32*AR_SIZE-1:0] in_data;
    logic                  cfg_wr_en;
    logic [3:0]            cfg_addr;
    logic [31:0]           cfg_data;
    logic                  cfg_err;
    logic                  out_wr_en;
    logic [15:0]           out_index;
    logic [8*AR_SIZE-1:0]  out_data;
    logic                  tile_done;
    logic                  busy;
    modport master (
        output in_wr_en, in_index, in_data, cfg_wr_en, cfg_addr, cfg_data,
        input  cfg_err, out_wr_en, out_index, out_data, tile_done, busy
    );
    modport slave (
        input  in_wr_en, in_index, in_data, cfg_wr_en, cfg_addr, cfg_data,
        output cfg_err, out_wr_en, out_index, out_data, tile_done, busy
    );
endinterface

// File: rtl/systolic_requant.sv
// systolic_requant: bias, Q31 multiply, rounding shift, offset and int8 clamp of systolic C rows.
// Per-lane mult/shift enabled by `SYSTOLIC_REQUANT_PER_CHANNEL_EN.
module systolic_requant #(
    parameter int AR_SIZE = 4,
    parameter int LATENCY = 4
) (
    input logic               clk,
    input logic               rst,
    systolic_requant_if.slave bus
);
    localparam int CW = $clog2(AR_SIZE);
    logic signed [31:0]   r_bias [AR_SIZE];
`ifdef SYSTOLIC_REQUANT_PER_CHANNEL_EN
    logic signed [31:0]   r_mult [AR_SIZE];
    logic [4:0]           r_shift [AR_SIZE];
`else
    logic signed [31:0]   r_mult;
    logic [4:0]           r_shift;
`endif
    logic signed [7:0]    r_offset, r_act_min, r_act_max;
    logic [LATENCY-1:0]   r_v;
    logic [15:0]          r_idx [LATENCY-1];
    logic [CW-1:0]        r_cnt;
    logic                 r_cfg_err, r_tile_done;
    logic [15:0]          r_out_index;
    logic [8*AR_SIZE-1:0] r_out_data;
    logic signed [31:0]   w_mult [AR_SIZE];
    logic [4:0]           w_shift [AR_SIZE];
    logic [8*AR_SIZE-1:0] w_pack;
    logic                 w_busy, w_cfg_ok, w_mapped;
    assign w_busy        = bus.in_wr_en | (|r_v);
    assign w_cfg_ok      = bus.cfg_wr_en & ~w_busy;
`ifdef SYSTOLIC_REQUANT_PER_CHANNEL_EN
    assign w_mapped      = 1'b1;
`else
    assign w_mapped      = ~bus.cfg_addr[3];
`endif
    assign bus.busy      = w_busy;
    assign bus.cfg_err   = r_cfg_err;
    assign bus.out_wr_en = r_v[LATENCY-1];
    assign bus.out_index = r_out_index;
    assign bus.out_data  = r_out_data;
    assign bus.tile_done = r_tile_done;
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < AR_SIZE; k++) begin
                r_bias[k] <= '0;
`ifdef SYSTOLIC_REQUANT_PER_CHANNEL_EN
                r_mult[k]  <= 32'sh7FFFFFFF;
                r_shift[k] <= '0;
`endif
            end
`ifndef SYSTOLIC_REQUANT_PER_CHANNEL_EN
            r_mult  <= 32'sh7FFFFFFF;
            r_shift <= '0;
`endif
            r_offset  <= '0;
            r_act_min <= 8'sh80;
            r_act_max <= 8'sh7F;
        end else if (w_cfg_ok) begin
            if (bus.cfg_addr < 4'(AR_SIZE)) r_bias[bus.cfg_addr[CW-1:0]] <= bus.cfg_data;
`ifdef SYSTOLIC_REQUANT_PER_CHANNEL_EN
            for (int k = 0; k < AR_SIZE; k++) begin
                if (bus.cfg_addr == 4'd4 || bus.cfg_addr == 4'(8 + k)) r_mult[k] <= bus.cfg_data;
                if (bus.cfg_addr == 4'd5 || bus.cfg_addr == 4'(12 + k)) r_shift[k] <= bus.cfg_data[4:0];
            end
`else
            if (bus.cfg_addr == 4'd4) r_mult <= bus.cfg_data;
            if (bus.cfg_addr == 4'd5) r_shift <= bus.cfg_data[4:0];
`endif
            if (bus.cfg_addr == 4'd6) r_offset <= bus.cfg_data[7:0];
            if (bus.cfg_addr == 4'd7) begin
                r_act_min <= bus.cfg_data[7:0];
                r_act_max <= bus.cfg_data[15:8];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v         <= '0;
            r_cnt       <= '0;
            r_cfg_err   <= 1'b0;
            r_tile_done <= 1'b0;
            r_out_index <= '0;
            r_out_data  <= '0;
        end else begin
            r_v         <= {r_v[LATENCY-2:0], bus.in_wr_en};
            r_cfg_err   <= bus.cfg_wr_en & w_busy & w_mapped;
            r_tile_done <= r_v[LATENCY-2] && r_cnt == CW'(AR_SIZE - 1);
            if (r_v[LATENCY-2]) begin
                r_cnt       <= r_cnt == CW'(AR_SIZE - 1) ? '0 : r_cnt + 1'b1;
                r_out_index <= r_idx[LATENCY-2];
                r_out_data  <= w_pack;
            end
        end
    end
    always_ff @(posedge clk) begin
        r_idx[0] <= bus.in_index;
        for (int k = 1; k < LATENCY - 1; k++) r_idx[k] <= r_idx[k-1];
    end
    for (genvar g = 0; g < AR_SIZE; g++) begin : g_lane
        logic signed [31:0] r_x, r_h, r_r, w_h, w_r;
        logic signed [63:0] w_p, w_t;
        logic signed [32:0] w_y, w_lo;
`ifdef SYSTOLIC_REQUANT_PER_CHANNEL_EN
        assign w_mult[g]  = r_mult[g];
        assign w_shift[g] = r_shift[g];
`else
        assign w_mult[g]  = r_mult;
        assign w_shift[g] = r_shift;
`endif
        assign w_p = 64'(r_x) * 64'(w_mult[g]);
        assign w_t = (w_p + 64'sd1073741824) >>> 31;
        // a Q31 product can only exceed int32 upward (-2^31 * -2^31)
        assign w_h = w_t > 64'sh7FFFFFFF ? 32'sh7FFFFFFF : w_t[31:0];
        assign w_r = w_shift[g] == 5'd0 ? r_h :
                     32'((33'(r_h) + (33'sd1 <<< (w_shift[g] - 5'd1))) >>> w_shift[g]);
        assign w_y  = 33'(r_r) + 33'(r_offset);
        assign w_lo = w_y < 33'(r_act_min) ? 33'(r_act_min) : w_y;
        assign w_pack[8*g +: 8] = 8'(w_lo > 33'(r_act_max) ? 33'(r_act_max) : w_lo);
        always_ff @(posedge clk) begin
            r_x <= $signed(bus.in_data[32*g +: 32]) + r_bias[g];
            r_h <= w_h;
            r_r <= w_r;
        end
    end
endmodule

// File: doc/systolic_requant.md
Name: systolic_requant

Overview:
- Output stage directly downstream of the 4x4 systolic array.
- Consumes the array's C write burst: one 128-bit row per cycle, holding four 32-bit accumulators.
- Per row, per lane: adds bias, applies fixed-point multiplier, rounding right shift, output offset and int8 clamp.
- Packs the four int8 results into one 32-bit word for the output buffer, with fixed latency and no backpressure.

Parameters:
- AR_SIZE, 4, number of lanes per row and number of rows per tile; tile_done fires after AR_SIZE rows.
- LATENCY, 4, pipeline depth from in_wr_en to out_wr_en; fixed and not meant to be overridden.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_wr_en  input  1  row valid; driven by the array's C write enable.
- in_index  input  16  row index; driven by the array's C index.
- in_data  input  128  accumulators; lane i = in_data[32*i +: 32], signed.
- cfg_wr_en  input  1  configuration register write strobe.
- cfg_addr  input  4  configuration register address.
- cfg_data  input  32  configuration write data.
- cfg_err  output  1  one-cycle pulse: configuration write rejected.
- out_wr_en  output  1  output word valid.
- out_index  output  16  in_index delayed by LATENCY.
- out_data  output  32  packed int8 results; byte i from lane i.
- tile_done  output  1  one-cycle pulse with the AR_SIZE-th output of a tile.
- busy  output  1  high while in_wr_en is high or any pipeline stage is valid.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All stage valids, the row counter, out_wr_en, tile_done and cfg_err go to 0.
  - out_data and out_index go to 0.
  - Config returns to defaults: bias[0..3]=0, mult=0x7FFFFFFF, shift=0, offset=0, act_min=-128, act_max=127.
  - Reset mid-burst discards in-flight rows; nothing is written for them.
- Config map:
  - 0-3: bias[i] (32b signed).
  - 4: mult (32b signed, Q31).
  - 5: shift = cfg_data[4:0].
  - 6: offset = cfg_data[7:0] (signed).
  - 7: act_min = cfg_data[7:0], act_max = cfg_data[15:8] (signed).
  - 8-15: per Optional Feature.
- Config write rules:
  - Accepted only when busy=0 at that edge.
  - When busy=1, the write is dropped and cfg_err pulses the next cycle.
  - cfg_wr_en in the same cycle as in_wr_en is rejected, because busy is high.
  - act_min > act_max is not checked; clamp applies min first, then max.
- Pipeline, per lane, one register stage each; rows accepted every cycle, back-to-back:
  - S1: x = acc + bias[i], 32-bit wrap-around.
  - S2: p = x * mult as a 64-bit signed product; h = (p + 2^30) >>> 31, saturated to int32. x = mult = -2^31 yields 0x7FFFFFFF.
  - S3: if shift=0, r = h; otherwise r = (h + 2^(shift-1)) >>> shift. Compute in 33 bits so there is no overflow.
  - S4: y = r + offset, then clamp to [act_min, act_max]. out_data byte i = y[7:0].
- Timing:
  - out_wr_en is asserted exactly 4 cycles after in_wr_en is sampled high.
  - out_index and out_data are valid in that same cycle.
  - Outputs hold their last value while out_wr_en=0.
- Row counter:
  - Increments on each out_wr_en.
  - On the AR_SIZE-th word, tile_done=1 in the same cycle as out_wr_en, and the counter wraps to 0.
  - A gap in in_wr_en does not reset the counter; only rst or wrap does.

Optional Feature:
- Macro: SYSTOLIC_REQUANT_PER_CHANNEL_EN.
- Defined:
  - Addresses 8-11 write mult[i] and addresses 12-15 write shift[i].
  - Lane i uses mult[i] and shift[i].
  - Addresses 4 and 5 broadcast-write all four lanes.
  - Reset: all mult[i]=0x7FFFFFFF, all shift[i]=0.
- Undefined:
  - A single shared mult and shift.
  - Writes to addresses 8-15 are silently ignored, with no cfg_err.

Test Plan:
- Defaults; single row, lanes {100, 300, -300, 0}, index 2 -> out_wr_en 4 cycles later, out_index 2, out_data 0x00_80_7F_64, no tile_done.
- Config bias0=5, mult=0x40000000, shift=1; lane0 acc 97 -> 102 -> 51 -> (51+1)>>1 = 26 -> byte0 = 0x1A.
- Four back-to-back rows, indices 0-3 -> four consecutive out_wr_en with indices 0-3; tile_done high only with index 3; busy falls the cycle after the last write.
- cfg_wr_en to addr 6 while busy -> cfg_err pulses 1 cycle; offset unchanged (next result identical to the prior config). With busy=0 and offset=-10, acc 20 -> byte 0x0A.
- Saturation: bias0=0, mult=0x80000000, lane0 acc 0x80000000 -> h = 0x7FFFFFFF -> clamped byte0 = 0x7F.
- rst asserted 2 cycles into a 4-row burst -> no out_wr_en for in-flight rows; config back to defaults; next burst produces tile_done on its 4th word.
